// File: rtl/c7bifu_pkg.sv
`default_nettype none
// ============================================================================
// Module : c7bifu_pkg
// Brief  : Shared fetch-control definitions (prefetch address select encoding)
// Rev    : 1.0  initial release
// ============================================================================
package c7bifu_pkg;

    localparam int PF_SEL_W = 6;

    // Bit positions inside the one-hot {init,old,inc,brn,isr,ert} select bus
    typedef enum logic [2:0] {
        SEL_ERT  = 3'd0,
        SEL_ISR  = 3'd1,
        SEL_BRN  = 3'd2,
        SEL_INC  = 3'd3,
        SEL_OLD  = 3'd4,
        SEL_INIT = 3'd5
    } pf_sel_e;

    function automatic logic [PF_SEL_W-1:0] pf_sel_onehot(input pf_sel_e s);
        logic [PF_SEL_W-1:0] v;
        v    = '0;
        v[s] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/c7bifu_fcl_udcnt.sv
`default_nettype none
// ============================================================================
// Module : c7bifu_fcl_udcnt
// Brief  : Saturating up/down counter with parallel load; exposes next value
// Rev    : 1.0  initial release
// ============================================================================
module c7bifu_fcl_udcnt #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_next
);

    // Simultaneous inc and dec cancel; saturation keeps the count in 0..MAX
    always_comb begin
        cnt_next = cnt;
        if (load) begin
            cnt_next = load_val;
        end else if (inc && !dec) begin
            if (cnt != W'(MAX)) cnt_next = cnt + W'(1);
        end else if (dec && !inc) begin
            if (cnt != '0) cnt_next = cnt - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else       cnt <= cnt_next;
    end

endmodule
`default_nettype wire

// File: rtl/c7bifu_fcl_mo.sv
`default_nettype none
// ============================================================================
// Module : c7bifu_fcl_mo
// Brief  : IFU fetch control - multiple-outstanding request issue, redirect
//          kill tracking and prefetch address select
// Rev    : 1.0  initial release
// ============================================================================
module c7bifu_fcl_mo
    import c7bifu_pkg::*;
#(
    parameter  int MAX_OUT = 4,
    parameter  int IQ_CW   = 4,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic                clk,
    input  logic                reset,
    output logic                ifu_icu_req_ic1,
    input  logic                icu_ifu_ack_ic1,
    input  logic                icu_ifu_data_valid_ic2,
    input  logic                exu_ifu_except,
    input  logic                exu_ifu_ertn,
    input  logic                exu_ifu_branch,
    input  logic                exu_ifu_stall,
    input  logic [IQ_CW-1:0]    iq_free,
    output logic [PF_SEL_W-1:0] pf_addr_sel,
    output logic                pf_addr_en,
    output logic                icu_data_vld,
    output logic                flush,
    output logic                stall,
    output logic [CNT_W-1:0]    outst_cnt
);

    localparam int CMP_W = (CNT_W + 1 > IQ_CW) ? CNT_W + 1 : IQ_CW;

    logic             init_q;
    logic             req_q;
    logic             req_n;
    logic             can_issue;
    logic             ack;
    logic             dv;
    logic             kill_dec;
    logic [CNT_W-1:0] outst_q;
    logic [CNT_W-1:0] outst_n;
    logic [CNT_W-1:0] kill_q;
    logic [CNT_W-1:0] kill_n;
    logic [CMP_W-1:0] live_n;

    assign ack   = icu_ifu_ack_ic1;
    assign dv    = icu_ifu_data_valid_ic2;
    assign flush = exu_ifu_except | exu_ifu_ertn | exu_ifu_branch;
    assign stall = exu_ifu_stall;

    // A return in the flush cycle is passed and already removed by outst_n
    assign kill_dec = dv & ~flush & (kill_q != '0);

    c7bifu_fcl_udcnt #(.MAX(MAX_OUT), .W(CNT_W)) u_outst (
        .clk      (clk),
        .reset    (reset),
        .inc      (ack),
        .dec      (dv),
        .load     (1'b0),
        .load_val ('0),
        .cnt      (outst_q),
        .cnt_next (outst_n)
    );

    c7bifu_fcl_udcnt #(.MAX(MAX_OUT), .W(CNT_W)) u_kill (
        .clk      (clk),
        .reset    (reset),
        .inc      (1'b0),
        .dec      (kill_dec),
        .load     (flush),
        .load_val (outst_n),
        .cnt      (kill_q),
        .cnt_next (kill_n)
    );

    // Killed returns are dropped before the IQ, so only live ones need credit
    always_comb begin
        live_n = '0;
        if (outst_n > kill_n) live_n = CMP_W'(outst_n - kill_n);
    end

    assign can_issue = ~init_q
                     & (outst_n < CNT_W'(MAX_OUT))
                     & (live_n < CMP_W'(iq_free));

    assign req_n = (req_q & ~ack) | can_issue;

    always_ff @(posedge clk) begin
        if (reset) begin
            init_q <= 1'b1;
            req_q  <= 1'b0;
        end else begin
            init_q <= 1'b0;
            req_q  <= req_n;
        end
    end

    always_comb begin
        pf_addr_sel = pf_sel_onehot(SEL_OLD);
        if (init_q || reset)   pf_addr_sel = pf_sel_onehot(SEL_INIT);
        else if (exu_ifu_except) pf_addr_sel = pf_sel_onehot(SEL_ISR);
        else if (exu_ifu_ertn)   pf_addr_sel = pf_sel_onehot(SEL_ERT);
        else if (exu_ifu_branch) pf_addr_sel = pf_sel_onehot(SEL_BRN);
        else if (ack)            pf_addr_sel = pf_sel_onehot(SEL_INC);
    end

    assign pf_addr_en      = init_q | reset | flush | ack;
    assign icu_data_vld    = dv & ~reset & (flush | (kill_q == '0));
    assign ifu_icu_req_ic1 = req_q;
    assign outst_cnt       = outst_q;

`ifndef SYNTHESIS
    a_outst_ovf: assert property (@(posedge clk) disable iff (reset)
        !(ack && !dv && outst_q == CNT_W'(MAX_OUT)))
        else $error("ack while outstanding count is at MAX_OUT");

    a_outst_unf: assert property (@(posedge clk) disable iff (reset)
        !(dv && !ack && outst_q == '0))
        else $error("data_valid with no outstanding request");
`endif

endmodule
`default_nettype wire

// File: tb/tb_c7bifu_fcl_mo.sv
`default_nettype none
// ============================================================================
// Module : tb_c7bifu_fcl_mo
// Brief  : Self-checking bench; in-flight fetches modelled as a queue of tags
// Rev    : 1.0  initial release
// ============================================================================
module tb_c7bifu_fcl_mo;

    localparam int MAX_OUT = 4;
    localparam int IQ_CW   = 4;
    localparam int CNT_W   = $clog2(MAX_OUT + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             req;
    logic             ack = 1'b0;
    logic             dv = 1'b0;
    logic             ex = 1'b0;
    logic             er = 1'b0;
    logic             br = 1'b0;
    logic             st = 1'b0;
    logic [IQ_CW-1:0] iq = '0;
    logic [5:0]       sel;
    logic             en;
    logic             vld;
    logic             fl;
    logic             stl;
    logic [CNT_W-1:0] cnt;

    always #5 clk = ~clk;

    c7bifu_fcl_mo #(.MAX_OUT(MAX_OUT), .IQ_CW(IQ_CW)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .ifu_icu_req_ic1        (req),
        .icu_ifu_ack_ic1        (ack),
        .icu_ifu_data_valid_ic2 (dv),
        .exu_ifu_except         (ex),
        .exu_ifu_ertn           (er),
        .exu_ifu_branch         (br),
        .exu_ifu_stall          (st),
        .iq_free                (iq),
        .pf_addr_sel            (sel),
        .pf_addr_en             (en),
        .icu_data_vld           (vld),
        .flush                  (fl),
        .stall                  (stl),
        .outst_cnt              (cnt)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference state: each in-flight fetch is a tag, 1 = will be dropped
    bit m_init;
    bit m_req;
    bit fq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] exp_sel(input bit i, input bit e, input bit r,
                                           input bit b, input bit a);
        if (i) return 6'b100000;
        if (e) return 6'b000010;
        if (r) return 6'b000001;
        if (b) return 6'b000100;
        if (a) return 6'b001000;
        return 6'b010000;
    endfunction

    task automatic step(input bit a_w, input bit d_w, input bit e, input bit r,
                        input bit b, input bit s, input int q);
        bit a, d, f;
        int live;
        a  = a_w & m_req;
        d  = d_w & (fq.size() > 0);
        f  = e | r | b;
        ack = a; dv = d; ex = e; er = r; br = b; st = s; iq = IQ_CW'(q);
        @(negedge clk);
        chk("req",      32'(req), 32'(m_req));
        chk("sel",      32'(sel), 32'(exp_sel(m_init, e, r, b, a)));
        chk("en",       32'(en),  32'(m_init | f | a));
        chk("data_vld", 32'(vld), 32'(d && (f || !fq[0])));
        chk("flush",    32'(fl),  32'(f));
        chk("stall",    32'(stl), 32'(s));
        chk("outst",    32'(cnt), 32'(fq.size()));
        if (a) fq.push_back(1'b0);
        if (d) void'(fq.pop_front());
        if (f) foreach (fq[k]) fq[k] = 1'b1;
        live = 0;
        foreach (fq[k]) if (!fq[k]) live++;
        m_req  = (m_req & ~a) | (!m_init && fq.size() < MAX_OUT && live < q);
        m_init = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        ack = 1'b0; ex = 1'b0; er = 1'b0; br = 1'b0; dv = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("rst_sel", 32'(sel), 32'(6'b100000));
            chk("rst_en",  32'(en),  32'd1);
            chk("rst_vld", 32'(vld), 32'd0);
            if (i > 0) begin
                chk("rst_req",   32'(req), 32'd0);
                chk("rst_outst", 32'(cnt), 32'd0);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
        dv    = 1'b0;
        fq.delete();
        m_init = 1'b1;
        m_req  = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset(3);

        // Reset release, ack one cycle after each request, fill to MAX_OUT
        for (int i = 0; i < 14; i++) step(i % 2 == 1, 0, 0, 0, 0, 0, 8);

        // One return, exception kills the remaining three, then a live one
        step(0, 1, 0, 0, 0, 0, 8);
        step(0, 0, 1, 0, 0, 0, 8);
        step(1, 0, 0, 0, 0, 0, 8);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 8);

        // Flush together with ack at one outstanding
        for (int i = 0; i < 3; i++) step(i == 2, 0, 0, 0, 0, 0, 8);
        step(1, 0, 1, 0, 0, 0, 8);
        step(1, 0, 0, 0, 0, 0, 8);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0, 8);

        // Redirect priority and stall pass-through
        step(0, 0, 1, 0, 1, 0, 8);
        step(0, 0, 0, 0, 1, 1, 8);
        step(0, 0, 0, 1, 1, 0, 8);
        step(1, 0, 0, 0, 0, 1, 8);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0, 8);

        // Limited IQ credit, then a flush frees it
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 0, 2);
        step(0, 0, 0, 0, 1, 0, 2);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 2);

        // Mid-operation reset with kills pending, then first return passes
        step(0, 0, 1, 0, 0, 0, 8);
        step(0, 1, 0, 0, 0, 0, 8);
        step(1, 0, 0, 0, 0, 0, 8);
        do_reset(2);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 8);
        step(0, 1, 0, 0, 0, 0, 8);
        step(0, 1, 0, 0, 0, 0, 8);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset(2);
            step($urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 4,
                 $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 6,
                 $urandom_range(0, 99) < 20,
                 int'($urandom_range(0, 15)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
